// File: rtl/d_debounce_pkg.sv
// -----------------------------------------------------------------------------
// d_debounce_pkg
// Shared definitions for the d_debounce input-conditioning block.
//   state_t        : debounce FSM state, 2-bit encoding
//   GLITCH_CNT_W   : width of the optional aborted-transition counter
//   sat_inc()      : saturating increment for the glitch counter
// Optional feature macro used by the top: D_DEBOUNCE_GLITCH_CNT_EN
// -----------------------------------------------------------------------------
package d_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam int GLITCH_CNT_W = 8;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/d_debounce_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser that brings an asynchronous level into the clk
// domain. Reusable for any single-bit asynchronous input.
// Parameters:
//   STAGES : number of synchroniser flops (2..4)
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset, clears every stage
//   d_in  in  asynchronous level
//   d_out out synchronised level (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    logic [STAGES-1:0] sync_q;

    // Bit 0 is the metastability-catching flop; the level shifts towards the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/d_debounce.sv
// -----------------------------------------------------------------------------
// d_debounce
// Synchronises a raw asynchronous level, filters glitches with a debounce
// counter and emits the clean level plus single-cycle rise/fall pulses.
// d_clean is intended to drive the d input of the downstream d_ff register.
// Parameters:
//   SYNC_STAGES     : synchroniser depth (2..4)
//   DEBOUNCE_CYCLES : consecutive edges a new level must persist (1..65535)
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-low reset
//   d_raw      in  raw asynchronous level
//   d_clean    out debounced, synchronised level
//   rise       out one-cycle pulse when d_clean goes 0->1
//   fall       out one-cycle pulse when d_clean goes 1->0
//   busy       out high while a candidate transition is being qualified
//   glitch_cnt out [7:0] saturating count of aborted transitions
//                  (present only when D_DEBOUNCE_GLITCH_CNT_EN is defined)
// -----------------------------------------------------------------------------
module d_debounce
    import d_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic d_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a single-cycle debounce the WAIT states are skipped entirely.
    localparam bit BYPASS = (DEBOUNCE_CYCLES == 1);

    logic             d_sync;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_raw),
        .d_out (d_sync)
    );

    // cnt_q counts consecutive edges on which d_sync has shown the candidate
    // level; entering WAIT already counts as the first one, so the commit
    // happens on the DEBOUNCE_CYCLES-th edge and cnt_q never exceeds
    // DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (d_sync) begin
                        if (BYPASS) begin
                            state_q <= STABLE_HI;
                            clean_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT_HI;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                WAIT_HI: begin
                    if (!d_sync) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        clean_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!d_sync) begin
                        if (BYPASS) begin
                            state_q <= STABLE_LO;
                            clean_q <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT_LO;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                WAIT_LO: begin
                    if (d_sync) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        clean_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    logic                    abort;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

    // An abort is a WAIT state seeing the old level return before commit.
    assign abort = ((state_q == WAIT_HI) && !d_sync) ||
                   ((state_q == WAIT_LO) &&  d_sync);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt_q <= '0;
        end else if (abort) begin
            glitch_cnt_q <= sat_inc(glitch_cnt_q);
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

    assign d_clean = clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_d_debounce.sv
// -----------------------------------------------------------------------------
// tb_d_debounce
// Directed bench for d_debounce. Main instance: SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Second instance: DEBOUNCE_CYCLES=1 boundary case.
// Expected output vectors {d_clean, rise, fall, busy} are queued when the
// input is changed and compared one per rising edge, 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_d_debounce;

    localparam int S = 2;
    localparam int D = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, d_raw;
    logic d_clean, rise, fall, busy;
    logic rst1, d_raw1;
    logic d_clean1, rise1, fall1, busy1;
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt, glitch_cnt1;
`endif

    d_debounce #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d_raw      (d_raw),
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .d_clean    (d_clean),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy)
    );

    d_debounce #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .d_raw      (d_raw1),
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt1),
`endif
        .d_clean    (d_clean1),
        .rise       (rise1),
        .fall       (fall1),
        .busy       (busy1)
    );

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic [3:0] exp1_q[$];
    int         assert_cnt = 0;
    int         fail_cnt   = 0;
    string      cur_tag    = "init";
    int         exp_glitch = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, comparing each instance against its queue head.
    task automatic run(input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(cur_tag, {d_clean, rise, fall, busy}, e);
            end
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                check({cur_tag, "_d1"}, {d_clean1, rise1, fall1, busy1}, e);
            end
        end
    endtask

    // Timeline after d_raw changes at edge 0 and is held: WAIT for edges
    // S+1..S+D-1, commit with a pulse on edge S+D, pulse gone on S+D+1.
    task automatic push_transition(input logic old_v, input logic new_v);
        logic b, c, p;
        for (int k = 1; k <= S + D + 1; k++) begin
            b = (k >= S + 1) && (k < S + D);
            c = (k >= S + D) ? new_v : old_v;
            p = (k == S + D);
            exp_q.push_back({c, p & new_v, p & ~new_v, b});
        end
    endtask

    // Raw pulse of w (< D) cycles away from level: busy on edges S+1..S+w.
    task automatic push_glitch(input logic level, input int w);
        for (int k = 1; k <= S + w + 2; k++) begin
            exp_q.push_back({level, 1'b0, 1'b0, (k >= S + 1) && (k <= S + w)});
        end
    endtask

    task automatic drive_glitch(input logic level, input int w);
        push_glitch(level, w);
        d_raw = ~level;
        run(w);
        d_raw = level;
        run(S + 2);
        exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b0;
        d_raw  = 1'b1;
        rst1   = 1'b0;
        d_raw1 = 1'b0;

        // Reset held with d_raw high: everything stays zero.
        cur_tag = "reset_hold";
        tick(); tick(); tick();
        check("reset_out", {d_clean, rise, fall, busy}, 4'b0000);
        check("reset_out_d1", {d_clean1, rise1, fall1, busy1}, 4'b0000);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch_cnt", glitch_cnt, 8'd0);
`endif

        // Release: d_clean rises on the 6th edge with one rise pulse.
        rst  = 1'b1;
        rst1 = 1'b1;
        cur_tag = "reset_release";
        push_transition(1'b0, 1'b1);
        run(S + D + 1);

        // Held input: no further pulses.
        cur_tag = "held_hi";
        for (int k = 0; k < 5; k++) exp_q.push_back(4'b1000);
        run(5);

        // Clean edges in both directions.
        cur_tag = "clean_fall";
        d_raw = 1'b0;
        push_transition(1'b1, 1'b0);
        run(S + D + 1);
        cur_tag = "clean_rise";
        d_raw = 1'b1;
        push_transition(1'b0, 1'b1);
        run(S + D + 1);
        cur_tag = "clean_fall2";
        d_raw = 1'b0;
        push_transition(1'b1, 1'b0);
        run(S + D + 1);

        // Glitches from the low level: directed width 2, then random widths.
        cur_tag = "glitch_lo_w2";
        drive_glitch(1'b0, 2);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_one", glitch_cnt, 8'd1);
`endif
        cur_tag = "glitch_lo_rand";
        for (int g = 0; g < 3; g++) drive_glitch(1'b0, $urandom_range(1, D - 1));

        // Glitches from the high level.
        cur_tag = "to_hi";
        d_raw = 1'b1;
        push_transition(1'b0, 1'b1);
        run(S + D + 1);
        cur_tag = "glitch_hi_rand";
        for (int g = 0; g < 2; g++) drive_glitch(1'b1, $urandom_range(1, D - 1));
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_multi", glitch_cnt, 8'(exp_glitch));
`endif

        // Back low, then reset two edges into WAIT_HI.
        cur_tag = "to_lo";
        d_raw = 1'b0;
        push_transition(1'b1, 1'b0);
        run(S + D + 1);
        cur_tag = "pre_reset_wait";
        d_raw = 1'b1;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        run(S + 2);
        rst = 1'b0;
        #1;
        check("midop_reset_async", {d_clean, rise, fall, busy}, 4'b0000);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        check("midop_reset_glitch_cnt", glitch_cnt, 8'd0);
        exp_glitch = 0;
`endif
        tick();
        check("midop_reset_held", {d_clean, rise, fall, busy}, 4'b0000);
        rst = 1'b1;
        cur_tag = "after_midop_reset";
        push_transition(1'b0, 1'b1);
        run(S + D + 1);
        d_raw = 1'b0;
        cur_tag = "after_midop_fall";
        push_transition(1'b1, 1'b0);
        run(S + D + 1);

        // DEBOUNCE_CYCLES=1: commit on edge S+1, 1-cycle pulses pass through.
        cur_tag = "d1_rise";
        d_raw1 = 1'b1;
        exp1_q.push_back(4'b0000);
        exp1_q.push_back(4'b0000);
        exp1_q.push_back(4'b1100);
        exp1_q.push_back(4'b1000);
        run(4);
        cur_tag = "d1_fall";
        d_raw1 = 1'b0;
        exp1_q.push_back(4'b1000);
        exp1_q.push_back(4'b1000);
        exp1_q.push_back(4'b0010);
        exp1_q.push_back(4'b0000);
        run(4);
        cur_tag = "d1_pulse";
        d_raw1 = 1'b1;
        exp1_q.push_back(4'b0000);
        run(1);
        d_raw1 = 1'b0;
        exp1_q.push_back(4'b0000);
        exp1_q.push_back(4'b1100);
        exp1_q.push_back(4'b0010);
        exp1_q.push_back(4'b0000);
        run(4);

`ifdef D_DEBOUNCE_GLITCH_CNT_EN
        // 300 two-cycle glitches: counter saturates, d_clean never moves.
        for (int g = 0; g < 300; g++) begin
            d_raw = 1'b1;
            tick(); tick();
            d_raw = 1'b0;
            tick(); tick(); tick(); tick();
        end
        check("glitch_cnt_saturate", glitch_cnt, 8'd255);
        check("saturate_clean_lo", d_clean, 1'b0);
`endif

        check("queue_drain", exp_q.size() + exp1_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
